psr_flag_controller: RTL and testbench
======================================

PSR_FLAG_CONTROLLER -- requirements
Module: psr_flag_controller

Interface
REQ-001 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-002 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-003 SHALL have port id_valid, input, 1: ID-stage instruction valid.
REQ-004 SHALL have port id_uses_flags, input, 1: ID instruction reads flags (conditional or carry-in).
REQ-005 SHALL have port id_cond, input, 4: ID instruction condition code (ARM encoding).
REQ-006 SHALL have port ex_valid, input, 1: EX-stage instruction valid.
REQ-007 SHALL have port ex_s_bit, input, 1: EX instruction sets flags (1 = set, 0 = keep).
REQ-008 SHALL have port alu_flags, input, 4: EX ALU flags {N,Z,C,V}.
REQ-009 SHALL have port flush, input, 1: squash the instruction currently in EX.
REQ-010 SHALL have port psr_wr_en, input, 1: direct PSR flag write (MSR-type), applied at edge.
REQ-011 SHALL have port psr_wr_data, input, 4: {N,Z,C,V} for direct write.
REQ-012 SHALL have port psr_flags, output, 4: architectural {N,Z,C,V}.
REQ-013 SHALL have port eval_flags, output, 4: flags presented to ID (forwarded or architectural).
REQ-014 SHALL have port cond_pass, output, 1: ID condition satisfied by eval_flags.
REQ-015 SHALL have port stall, output, 1: hold ID/IF one cycle; insert bubble into EX.

Function
REQ-016 SHALL hold a MEM flag stage {mem_set, mem_flags}; at each edge mem_set <= ex_valid & ex_s_bit & ~flush and mem_flags <= alu_flags.
REQ-017 SHALL commit mem_flags into psr_flags at the edge ending MEM when mem_set=1 (two-cycle latency from EX to architectural).
REQ-018 SHALL leave psr_flags unchanged when mem_set=0 (s_bit=0 keeps PSR).
REQ-019 SHALL, when psr_wr_en and mem_set coincide, load psr_wr_data (direct write wins; it is younger).
REQ-020 SHALL drive eval_flags = mem_flags when mem_set=1, else psr_flags (combinational forward from MEM).
REQ-021 SHALL assert stall combinationally when id_valid & id_uses_flags & ex_valid & ex_s_bit & ~flush; no forward from ALU.
REQ-022 SHALL limit any stall to one cycle: the flag-setter reaches MEM next cycle and is forwarded per REQ-020.
REQ-023 SHALL deassert stall when id_valid=0, id_uses_flags=0, or flush=1.
REQ-024 SHALL compute cond_pass from id_cond and eval_flags per ARM: EQ Z, NE !Z, CS C, CC !C, MI N, PL !N, VS V, VC !V, HI C&!Z, LS !C|Z, GE N==V, LT N!=V, GT !Z&(N==V), LE Z|(N!=V), AL 1, 1111 -> 0.
REQ-025 SHALL force cond_pass=0 while stall=1 or id_valid=0.
REQ-026 SHALL ignore alu_flags when ex_valid=0 or ex_s_bit=0 (no capture, no stall).

Reset
REQ-027 SHALL on reset clear psr_flags=4'b0000, mem_set=0, mem_flags=4'b0000; reset overrides psr_wr_en and in-flight commits.
REQ-028 SHALL produce stall=0 and cond_pass=0 in the cycle reset is asserted, and eval_flags=0000 in the first cycle after.

Structure
REQ-029 SHALL place condition-code constants (EQ..NV), flag bit indices (N=3,Z=2,C=1,V=0) and the flag width in a shared package.
REQ-030 SHALL implement condition decode as combinational sub-module cond_eval (cond[3:0], flags[3:0] -> pass).
REQ-031 SHALL contain only the 9 flop bits of REQ-016/017; no other state.

Verification
REQ-032 SHALL test: reset, then EX SUBS with alu_flags=0100 -> psr_flags=0100 two edges later; eval_flags=0100 one edge later.
REQ-033 SHALL test: EX flag-setter (0100) with ID BEQ -> stall=1 one cycle, next cycle cond_pass=1 via forward, stall=0.
REQ-034 SHALL test: same as REQ-033 with flush=1 -> stall=0, mem_set stays 0, psr_flags unchanged.
REQ-035 SHALL test: psr_wr_en with psr_wr_data=1001 coincident with mem_set carrying 0110 -> psr_flags=1001.
REQ-036 SHALL test: all 16 id_cond values against flags 0000, 1001, 0110, 1111 -> cond_pass matches REQ-024 table.
REQ-037 SHALL test: reset asserted while mem_set=1 -> psr_flags=0000, no commit next cycle.

Source files
------------

// File: rtl/psr_flag_controller_pkg.sv
// Shared definitions for the PSR flag controller.
// Flag vector layout is {N,Z,C,V}. Condition codes follow the ARM encoding.
package psr_flag_controller_pkg;

    // Width of the flag vector and position of each flag within it.
    localparam int FLAG_W = 4;
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // ARM condition codes.
    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

endpackage

// File: rtl/cond_eval.sv
// cond_eval: combinational ARM condition-code evaluator.
// Ports:
//   cond  [3:0] - ARM condition code
//   flags [3:0] - {N,Z,C,V} to test against
//   pass        - 1 when the condition holds (NV never holds)
module cond_eval
    import psr_flag_controller_pkg::*;
(
    input  logic [3:0]        cond,
    input  logic [FLAG_W-1:0] flags,
    output logic              pass
);

    logic n_s;
    logic z_s;
    logic c_s;
    logic v_s;

    assign n_s = flags[FLAG_N];
    assign z_s = flags[FLAG_Z];
    assign c_s = flags[FLAG_C];
    assign v_s = flags[FLAG_V];

    // Decode the condition against the individual flags.
    always_comb begin
        pass = 1'b0;
        case (cond)
            COND_EQ: pass = z_s;
            COND_NE: pass = ~z_s;
            COND_CS: pass = c_s;
            COND_CC: pass = ~c_s;
            COND_MI: pass = n_s;
            COND_PL: pass = ~n_s;
            COND_VS: pass = v_s;
            COND_VC: pass = ~v_s;
            COND_HI: pass = c_s & ~z_s;
            COND_LS: pass = ~c_s | z_s;
            COND_GE: pass = (n_s == v_s);
            COND_LT: pass = (n_s != v_s);
            COND_GT: pass = ~z_s & (n_s == v_s);
            COND_LE: pass = z_s | (n_s != v_s);
            COND_AL: pass = 1'b1;
            COND_NV: pass = 1'b0;
            default: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/psr_flag_controller.sv
// psr_flag_controller: architectural {N,Z,C,V} register with a one-deep MEM
// flag stage, MEM->ID forwarding, EX flag-setter interlock and ID condition
// evaluation.
// Ports:
//   clk, reset            - clock, synchronous active-high reset
//   id_valid/id_uses_flags/id_cond - ID-stage instruction and its condition
//   ex_valid/ex_s_bit/alu_flags    - EX-stage instruction and its ALU flags
//   flush                 - squash the instruction currently in EX
//   psr_wr_en/psr_wr_data - direct flag write (MSR-type)
//   psr_flags             - architectural flags
//   eval_flags            - flags seen by ID (forwarded from MEM or arch)
//   cond_pass             - ID condition satisfied
//   stall                 - hold ID/IF one cycle, bubble into EX
module psr_flag_controller
    import psr_flag_controller_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic              id_uses_flags,
    input  logic [3:0]        id_cond,
    input  logic              ex_valid,
    input  logic              ex_s_bit,
    input  logic [FLAG_W-1:0] alu_flags,
    input  logic              flush,
    input  logic              psr_wr_en,
    input  logic [FLAG_W-1:0] psr_wr_data,
    output logic [FLAG_W-1:0] psr_flags,
    output logic [FLAG_W-1:0] eval_flags,
    output logic              cond_pass,
    output logic              stall
);

    logic              mem_set_q;
    logic              mem_set_d;
    logic [FLAG_W-1:0] mem_flags_q;
    logic [FLAG_W-1:0] mem_flags_d;
    logic [FLAG_W-1:0] psr_q;
    logic [FLAG_W-1:0] psr_d;
    logic              ex_sets_s;
    logic              pass_raw_s;

    // A squashed or non-setting EX instruction never produces flags.
    assign ex_sets_s = ex_valid & ex_s_bit & ~flush;

    // Next-state for the MEM flag stage and the architectural flags.
    always_comb begin
        mem_set_d   = ex_sets_s;
        mem_flags_d = alu_flags;
        psr_d       = psr_q;
        // The direct write is younger than the instruction in MEM, so it wins.
        if (psr_wr_en) begin
            psr_d = psr_wr_data;
        end else if (mem_set_q) begin
            psr_d = mem_flags_q;
        end else begin
            psr_d = psr_q;
        end
    end

    // State registers; reset overrides both the direct write and the commit.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_set_q   <= 1'b0;
            mem_flags_q <= 4'b0000;
            psr_q       <= 4'b0000;
        end else begin
            mem_set_q   <= mem_set_d;
            mem_flags_q <= mem_flags_d;
            psr_q       <= psr_d;
        end
    end

    assign psr_flags  = psr_q;
    assign eval_flags = mem_set_q ? mem_flags_q : psr_q;

    // ALU flags are not forwarded: a reader behind a setter waits one cycle
    // until the setter reaches MEM. Suppressed while reset is asserted.
    assign stall = ~reset & id_valid & id_uses_flags & ex_sets_s;

    cond_eval u_cond_eval (
        .cond  (id_cond),
        .flags (eval_flags),
        .pass  (pass_raw_s)
    );

    assign cond_pass = ~reset & id_valid & ~stall & pass_raw_s;

endmodule

// File: tb/tb_psr_flag_controller.sv
// Self-checking bench for psr_flag_controller: directed scenarios plus
// randomized traffic, compared against a behavioural model every cycle.
module tb_psr_flag_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic       id_valid;
    logic       id_uses_flags;
    logic [3:0] id_cond;
    logic       ex_valid;
    logic       ex_s_bit;
    logic [3:0] alu_flags;
    logic       flush;
    logic       psr_wr_en;
    logic [3:0] psr_wr_data;
    logic [3:0] psr_flags;
    logic [3:0] eval_flags;
    logic       cond_pass;
    logic       stall;

    int total = 0;
    int bad   = 0;

    // Model: committed flags plus the flags of the setter that left EX last cycle.
    logic [3:0] m_arch;
    logic       m_inflight;
    logic [3:0] m_inflight_flags;

    always #5 clk = ~clk;

    psr_flag_controller dut (
        .clk           (clk),
        .reset         (reset),
        .id_valid      (id_valid),
        .id_uses_flags (id_uses_flags),
        .id_cond       (id_cond),
        .ex_valid      (ex_valid),
        .ex_s_bit      (ex_s_bit),
        .alu_flags     (alu_flags),
        .flush         (flush),
        .psr_wr_en     (psr_wr_en),
        .psr_wr_data   (psr_wr_data),
        .psr_flags     (psr_flags),
        .eval_flags    (eval_flags),
        .cond_pass     (cond_pass),
        .stall         (stall)
    );

    task automatic check_eq(input string tag, input logic [3:0] got, input logic [3:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%b expected=%b at %0t", tag, got, exp, $time);
        end
    endtask

    // ARM condition semantics: pairs of codes share a predicate, odd code inverts it.
    function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v, base;
        logic [2:0] grp;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        if (c == 4'd14) return 1'b1;
        if (c == 4'd15) return 1'b0;
        grp = c[3:1];
        case (grp)
            3'd0: base = z;
            3'd1: base = cy;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cy && !z;
            3'd5: base = (n == v);
            default: base = !z && (n == v);
        endcase
        return c[0] ? !base : base;
    endfunction

    task automatic idle_inputs();
        reset = 1'b0; id_valid = 1'b0; id_uses_flags = 1'b0; id_cond = 4'd0;
        ex_valid = 1'b0; ex_s_bit = 1'b0; alu_flags = 4'd0; flush = 1'b0;
        psr_wr_en = 1'b0; psr_wr_data = 4'd0;
    endtask

    // Check outputs for the currently driven inputs, then advance one clock.
    task automatic cycle();
        logic       e_stall;
        logic [3:0] e_eval;
        logic       e_pass;
        #2;
        e_stall = !reset && id_valid && id_uses_flags && ex_valid && ex_s_bit && !flush;
        e_eval  = m_inflight ? m_inflight_flags : m_arch;
        e_pass  = !reset && id_valid && !e_stall && ref_cond(id_cond, e_eval);
        check_eq("stall", {3'b000, stall}, {3'b000, e_stall});
        check_eq("eval_flags", eval_flags, e_eval);
        check_eq("cond_pass", {3'b000, cond_pass}, {3'b000, e_pass});
        check_eq("psr_flags", psr_flags, m_arch);
        @(posedge clk);
        if (reset) begin
            m_arch = 4'd0; m_inflight = 1'b0; m_inflight_flags = 4'd0;
        end else begin
            if (psr_wr_en) m_arch = psr_wr_data;
            else if (m_inflight) m_arch = m_inflight_flags;
            m_inflight       = ex_valid && ex_s_bit && !flush;
            m_inflight_flags = alu_flags;
        end
        #1;
    endtask

    task automatic write_psr(input logic [3:0] d);
        idle_inputs(); psr_wr_en = 1'b1; psr_wr_data = d; cycle();
        idle_inputs(); cycle();
    endtask

    initial begin
        logic [3:0] pats [4];
        pats[0] = 4'b0000; pats[1] = 4'b1001; pats[2] = 4'b0110; pats[3] = 4'b1111;
        m_arch = 4'd0; m_inflight = 1'b0; m_inflight_flags = 4'd0;
        idle_inputs();
        @(posedge clk); #1;

        // Reset with busy inputs: no stall, no pass, direct write ignored.
        reset = 1'b1; id_valid = 1'b1; id_uses_flags = 1'b1; id_cond = 4'b1110;
        ex_valid = 1'b1; ex_s_bit = 1'b1; alu_flags = 4'b1111;
        psr_wr_en = 1'b1; psr_wr_data = 4'b1111;
        #2;
        check_eq("rst_stall", {3'b000, stall}, 4'b0000);
        check_eq("rst_pass", {3'b000, cond_pass}, 4'b0000);
        #1;
        cycle(); cycle();
        idle_inputs();
        #1;
        check_eq("post_rst_eval", eval_flags, 4'b0000);
        check_eq("post_rst_psr", psr_flags, 4'b0000);

        // SUBS setting Z: forwarded after one edge, architectural after two.
        ex_valid = 1'b1; ex_s_bit = 1'b1; alu_flags = 4'b0100; cycle();
        idle_inputs();
        check_eq("subs_eval_1", eval_flags, 4'b0100);
        check_eq("subs_psr_1", psr_flags, 4'b0000);
        cycle();
        check_eq("subs_psr_2", psr_flags, 4'b0100);

        // Setter in EX with BEQ in ID: one stall, then pass via forward.
        write_psr(4'b0000);
        id_valid = 1'b1; id_uses_flags = 1'b1; id_cond = 4'b0000;
        ex_valid = 1'b1; ex_s_bit = 1'b1; alu_flags = 4'b0100;
        #2;
        check_eq("beq_stall", {3'b000, stall}, 4'b0001);
        check_eq("beq_pass_stalled", {3'b000, cond_pass}, 4'b0000);
        #1; cycle();
        ex_valid = 1'b0; ex_s_bit = 1'b0;
        #2;
        check_eq("beq_stall_2", {3'b000, stall}, 4'b0000);
        check_eq("beq_pass_fwd", {3'b000, cond_pass}, 4'b0001);
        #1; cycle();

        // Same with flush: no stall, setter dropped, flags untouched.
        write_psr(4'b0000);
        id_valid = 1'b1; id_uses_flags = 1'b1; id_cond = 4'b0000;
        ex_valid = 1'b1; ex_s_bit = 1'b1; alu_flags = 4'b0100; flush = 1'b1;
        #2;
        check_eq("flush_stall", {3'b000, stall}, 4'b0000);
        #1; cycle();
        idle_inputs();
        check_eq("flush_eval", eval_flags, 4'b0000);
        cycle();
        check_eq("flush_psr", psr_flags, 4'b0000);

        // Direct write coincident with a commit from MEM: write wins.
        ex_valid = 1'b1; ex_s_bit = 1'b1; alu_flags = 4'b0110; cycle();
        idle_inputs(); psr_wr_en = 1'b1; psr_wr_data = 4'b1001; cycle();
        idle_inputs();
        check_eq("wr_wins_psr", psr_flags, 4'b1001);
        cycle();
        check_eq("wr_wins_psr_2", psr_flags, 4'b1001);

        // Full condition table against four flag patterns.
        for (int p = 0; p < 4; p++) begin
            write_psr(pats[p]);
            for (int c = 0; c < 16; c++) begin
                idle_inputs(); id_valid = 1'b1; id_uses_flags = 1'b1; id_cond = 4'(c);
                cycle();
            end
        end

        // Reset while a setter sits in MEM: nothing commits.
        idle_inputs(); ex_valid = 1'b1; ex_s_bit = 1'b1; alu_flags = 4'b1111; cycle();
        idle_inputs(); reset = 1'b1; cycle();
        idle_inputs();
        check_eq("rst_mem_psr", psr_flags, 4'b0000);
        cycle();
        check_eq("rst_mem_psr_2", psr_flags, 4'b0000);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            reset         = ($urandom_range(0, 59) == 0);
            id_valid      = 1'($urandom);
            id_uses_flags = 1'($urandom);
            id_cond       = 4'($urandom);
            ex_valid      = 1'($urandom);
            ex_s_bit      = 1'($urandom);
            alu_flags     = 4'($urandom);
            flush         = ($urandom_range(0, 5) == 0);
            psr_wr_en     = ($urandom_range(0, 7) == 0);
            psr_wr_data   = 4'($urandom);
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
